// File: rtl/alun_pkg.sv
// rtl/alun_pkg.sv - shared opcodes, FSM states and flag indices for alun_seq
// Purpose: common definitions imported by the alun_seq datapath and its bench.
// Ports: none (package).
package alun_pkg;

  localparam logic [3:0] OP_NOT  = 4'h0;
  localparam logic [3:0] OP_AND  = 4'h1;
  localparam logic [3:0] OP_PASS = 4'h2;
  localparam logic [3:0] OP_OR   = 4'h3;
  localparam logic [3:0] OP_DEC  = 4'h4;
  localparam logic [3:0] OP_ADD  = 4'h5;
  localparam logic [3:0] OP_SUB  = 4'h6;
  localparam logic [3:0] OP_INC  = 4'h7;
  localparam logic [3:0] OP_ADC  = 4'h8;
  localparam logic [3:0] OP_SBC  = 4'h9;
  localparam logic [3:0] OP_SHL  = 4'hA;
  localparam logic [3:0] OP_SHR  = 4'hB;
  localparam logic [3:0] OP_MUL  = 4'hC;
  localparam logic [3:0] OP_MULH = 4'hD;
  localparam logic [3:0] OP_XOR  = 4'hE;
  localparam logic [3:0] OP_CLRC = 4'hF;

  // Flag register layout is {C,V,Z,N}.
  localparam int FLAG_N = 0;
  localparam int FLAG_Z = 1;
  localparam int FLAG_V = 2;
  localparam int FLAG_C = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/alun_seq_if.sv
// rtl/alun_seq_if.sv - request/result handshake bundle for alun_seq
// Purpose: groups the request side (in_*, op, operands) and result side
//   (out_*, f, flags) of alun_seq.
// Ports: master = requester/consumer, slave = alun_seq.
interface alun_seq_if #(parameter int N = 8);
  logic         in_valid;
  logic         in_ready;
  logic [3:0]   op;
  logic         use_acc;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] f;
  logic         c;
  logic         v;
  logic         z;
  logic         n;

  modport master (
    output in_valid, op, use_acc, a, b, out_ready,
    input  in_ready, out_valid, f, c, v, z, n
  );

  modport slave (
    input  in_valid, op, use_acc, a, b, out_ready,
    output in_ready, out_valid, f, c, v, z, n
  );
endinterface

// File: rtl/alun.sv
// rtl/alun.sv - combinational ALU for the {m,s1,s0} opcode group
// Purpose: sel[2]=0 logic ops (~A, A&B, A, A|B); sel[2]=1 adder ops
//   (A-1, A+B, A-B, A+1) with carry-out and signed overflow.
// Ports: sel[2:0], a, b in; f, c (carry / no-borrow), v (overflow) out.
module alun #(parameter int N = 8) (
  input  logic [2:0]   sel,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] f,
  output logic         c,
  output logic         v
);
  logic [N-1:0] y;
  logic         cin;
  logic [N-2:0] low;
  logic         c_msb;
  logic         sum_msb;
  logic         c_out;

  always_comb begin
    y   = b;
    cin = 1'b0;
    case (sel[1:0])
      2'b00:   y = '1;                      // decrement: A + all-ones
      2'b01:   y = b;
      2'b10:   begin y = ~b; cin = 1'b1; end
      default: begin y = '0; cin = 1'b1; end
    endcase
    // Split at the MSB so the carry into it is visible for V.
    {c_msb, low}     = {1'b0, a[N-2:0]} + {1'b0, y[N-2:0]} + {{(N-1){1'b0}}, cin};
    {c_out, sum_msb} = {1'b0, a[N-1]} + {1'b0, y[N-1]} + {1'b0, c_msb};

    f = '0;
    c = 1'b0;
    v = 1'b0;
    if (sel[2]) begin
      f = {sum_msb, low};
      c = c_out;
      v = c_msb ^ c_out;
    end else begin
      case (sel[1:0])
        2'b00:   f = ~a;
        2'b01:   f = a & b;
        2'b10:   f = a;
        default: f = a | b;
      endcase
    end
  end
endmodule

// File: rtl/alun_mul_serial.sv
// rtl/alun_mul_serial.sv - N-step shift-add multiplier
// Purpose: start latches operands; one partial product per cycle for N cycles.
//   done is high in the final step cycle, when product already includes that
//   step, so the caller can register it on the same edge.
// Ports: clk, rst, start, a, b in; done, product[2N-1:0] out.
module alun_mul_serial #(parameter int N = 8) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic           done,
  output logic [2*N-1:0] product
);
  localparam int CW = $clog2(N + 1);

  logic [2*N-1:0] mcand_q;
  logic [2*N-1:0] prod_q;
  logic [N-1:0]   mplier_q;
  logic [CW-1:0]  cnt_q;

  assign product = prod_q + (mplier_q[0] ? mcand_q : '0);
  assign done    = (cnt_q == CW'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand_q  <= '0;
      prod_q   <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
    end else if (start) begin
      mcand_q  <= {{N{1'b0}}, a};
      prod_q   <= '0;
      mplier_q <= b;
      cnt_q    <= CW'(N);
    end else if (cnt_q != '0) begin
      prod_q   <= product;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      cnt_q    <= cnt_q - CW'(1);
    end
  end
endmodule

// File: rtl/alun_seq.sv
// rtl/alun_seq.sv - clocked ALU with accumulator, flag register and handshakes
// Purpose: ops 0-7 through alun; ADC/SBC, shifts, XOR, CLRC in one cycle;
//   MUL/MULH through the serial multiplier (N extra cycles).
// Ports: clk, rst (async, active-high); bus (alun_seq_if.slave):
//   in_valid/in_ready/op/use_acc/a/b request, out_valid/out_ready/f/c/v/z/n result.
module alun_seq
  import alun_pkg::*;
#(parameter int N = 8) (
  input  logic     clk,
  input  logic     rst,
  alun_seq_if.slave bus
);
  state_t         state_q, state_d;
  logic [N-1:0]   acc_q, f_q;
  logic [3:0]     flags_q;
  logic           mulh_q;
  logic           accept, load_res, mul_start, is_mul;
  logic           mul_done;
  logic [2*N-1:0] product;
  logic [N-1:0]   opa, alu_f, res_f;
  logic           alu_c, alu_v, res_c, res_v;
  logic [N-1:0]   adc_y;
  logic [N-2:0]   adc_low;
  logic           adc_cmsb, adc_msb, adc_cout;

  assign opa    = bus.use_acc ? acc_q : bus.a;
  assign is_mul = (bus.op == OP_MUL) || (bus.op == OP_MULH);

  alun #(.N(N)) u_alun (
    .sel(bus.op[2:0]), .a(opa), .b(bus.b), .f(alu_f), .c(alu_c), .v(alu_v)
  );

  alun_mul_serial #(.N(N)) u_mul (
    .clk(clk), .rst(rst), .start(mul_start), .a(opa), .b(bus.b),
    .done(mul_done), .product(product)
  );

  assign bus.in_ready  = !rst && ((state_q == ST_IDLE) ||
                                  ((state_q == ST_DONE) && bus.out_ready));
  assign accept        = bus.in_valid && bus.in_ready;
  assign bus.out_valid = (state_q == ST_DONE);
  assign bus.f         = f_q;
  assign bus.c         = flags_q[FLAG_C];
  assign bus.v         = flags_q[FLAG_V];
  assign bus.z         = flags_q[FLAG_Z];
  assign bus.n         = flags_q[FLAG_N];

  // ADC/SBC carry chain: carry-in is the stored C flag.
  always_comb begin
    adc_y = bus.op[0] ? ~bus.b : bus.b;
    {adc_cmsb, adc_low} = {1'b0, opa[N-2:0]} + {1'b0, adc_y[N-2:0]} +
                          {{(N-1){1'b0}}, flags_q[FLAG_C]};
    {adc_cout, adc_msb} = {1'b0, opa[N-1]} + {1'b0, adc_y[N-1]} + {1'b0, adc_cmsb};
  end

  always_comb begin
    res_f = '0;
    res_c = 1'b0;
    res_v = 1'b0;
    if (state_q == ST_EXEC) begin
      if (mulh_q) begin
        res_f = product[2*N-1:N];
      end else begin
        res_f = product[N-1:0];
        res_c = |product[2*N-1:N];
      end
    end else if (!bus.op[3]) begin
      res_f = alu_f;
      res_c = alu_c;
      res_v = alu_v;
    end else begin
      case (bus.op)
        OP_ADC, OP_SBC: begin
          res_f = {adc_msb, adc_low};
          res_c = adc_cout;
          res_v = adc_cmsb ^ adc_cout;
        end
        OP_SHL:  begin res_f = {opa[N-2:0], 1'b0}; res_c = opa[N-1]; end
        OP_SHR:  begin res_f = {1'b0, opa[N-1:1]}; res_c = opa[0]; end
        OP_XOR:  res_f = opa ^ bus.b;
        OP_CLRC: res_f = opa;
        default: res_f = '0;   // MUL/MULH results come from EXEC
      endcase
    end
  end

  always_comb begin
    state_d   = state_q;
    load_res  = 1'b0;
    mul_start = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (accept) begin
          if (is_mul) begin
            mul_start = 1'b1;
            state_d   = ST_EXEC;
          end else begin
            load_res = 1'b1;
            state_d  = ST_DONE;
          end
        end else if ((state_q == ST_DONE) && bus.out_ready) begin
          state_d = ST_IDLE;
        end
      end
      ST_EXEC: begin
        if (mul_done) begin
          load_res = 1'b1;
          state_d  = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q   <= '0;
      f_q     <= '0;
      flags_q <= '0;
      mulh_q  <= 1'b0;
    end else begin
      if (mul_start) mulh_q <= bus.op[0];
      if (load_res) begin
        f_q             <= res_f;
        acc_q           <= res_f;
        flags_q[FLAG_C] <= res_c;
        flags_q[FLAG_V] <= res_v;
        flags_q[FLAG_Z] <= (res_f == '0);
        flags_q[FLAG_N] <= res_f[N-1];
      end
    end
  end
endmodule
